// File: rtl/puzzle_pkg.sv
// rtl/puzzle_pkg.sv - shared keycodes, cell codes, directions and states for the puzzle cursor writer
package puzzle_pkg;

  // USB HID keycodes the writer understands
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_Z     = 8'h1D;
  localparam logic [7:0] KEY_BKSP  = 8'h2A;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;

  // Grid cell byte values
  localparam logic [7:0] CELL_EMPTY = 8'h00;
  localparam logic [7:0] CELL_BLOCK = 8'h23;
  localparam logic [7:0] CHAR_A     = 8'h41;

  typedef enum logic [1:0] {
    DIR_R,
    DIR_L,
    DIR_D,
    DIR_U
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_STEP,
    ST_RD,
    ST_WAIT,
    ST_CHK
  } state_e;

endpackage

// File: rtl/puzzle_cell_addr.sv
// rtl/puzzle_cell_addr.sv - maps a grid cell to its RAM word address and byte lane
module puzzle_cell_addr #(
  parameter int COLS      = 15,
  parameter int BASE_WORD = 0
) (
  input  logic [4:0]  row_i,
  input  logic [4:0]  col_i,
  output logic [12:0] addr_o,
  output logic [3:0]  byte_en_o,
  output logic [1:0]  lane_o
);

  // Linear cell index; 32x32 grid fits in 11 bits
  logic [10:0] idx;

  assign idx       = 11'(row_i) * 11'(COLS) + 11'(col_i);
  assign addr_o    = 13'(BASE_WORD) + {4'b0000, idx[10:2]};
  assign lane_o    = idx[1:0];
  assign byte_en_o = 4'b0001 << idx[1:0];

endmodule

// File: rtl/puzzle_cursor_writer.sv
// rtl/puzzle_cursor_writer.sv - keycode-driven cell writer and block-skipping cursor mover
module puzzle_cursor_writer
  import puzzle_pkg::*;
#(
  parameter int ROWS       = 15,
  parameter int COLS       = 15,
  parameter int BASE_WORD  = 0,
  parameter int RD_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [4:0]  cursor_row,
  output logic [4:0]  cursor_col,
  output logic [12:0] AVL_ADDR,
  output logic [3:0]  AVL_BYTE_EN,
  output logic        AVL_CS,
  output logic        AVL_READ,
  output logic        AVL_WRITE,
  output logic [31:0] AVL_WRITEDATA,
  input  logic [31:0] AVL_READDATA
);

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic [4:0]  cur_col_q, cur_col_d;
  logic [4:0]  cand_row_q, cand_row_d;
  logic [4:0]  cand_col_q, cand_col_d;
  logic [5:0]  tries_q, tries_d;
  logic [1:0]  wait_q, wait_d;
  logic [7:0]  char_q, char_d;

  logic [4:0]  step_row, step_col;
  logic [4:0]  addr_row, addr_col;
  logic [12:0] cell_addr;
  logic [3:0]  cell_be;
  logic [1:0]  cell_lane;
  logic [7:0]  rd_byte;
  logic        horiz;
  logic [5:0]  span;

  // The write targets the cursor cell; every read (and its check) targets the candidate
  assign addr_row = (state_q == ST_WR) ? cur_row_q : cand_row_q;
  assign addr_col = (state_q == ST_WR) ? cur_col_q : cand_col_q;

  puzzle_cell_addr #(
    .COLS      (COLS),
    .BASE_WORD (BASE_WORD)
  ) u_cell_addr (
    .row_i     (addr_row),
    .col_i     (addr_col),
    .addr_o    (cell_addr),
    .byte_en_o (cell_be),
    .lane_o    (cell_lane)
  );

  assign rd_byte    = AVL_READDATA[{cell_lane, 3'b000} +: 8];
  assign horiz      = (dir_q == DIR_R) || (dir_q == DIR_L);
  assign span       = horiz ? 6'(COLS) : 6'(ROWS);
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;

  // Candidate moved one cell in the latched direction, wrapping within its row or column
  always_comb begin
    step_row = cand_row_q;
    step_col = cand_col_q;
    case (dir_q)
      DIR_R:   step_col = (cand_col_q == 5'(COLS - 1)) ? 5'd0 : cand_col_q + 5'd1;
      DIR_L:   step_col = (cand_col_q == 5'd0) ? 5'(COLS - 1) : cand_col_q - 5'd1;
      DIR_D:   step_row = (cand_row_q == 5'(ROWS - 1)) ? 5'd0 : cand_row_q + 5'd1;
      DIR_U:   step_row = (cand_row_q == 5'd0) ? 5'(ROWS - 1) : cand_row_q - 5'd1;
      default: ;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_R;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      cand_row_q <= '0;
      cand_col_q <= '0;
      tries_q    <= '0;
      wait_q     <= '0;
      char_q     <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      tries_q    <= tries_d;
      wait_q     <= wait_d;
      char_q     <= char_d;
    end
  end

  // Next-state logic and bus strobes; the bus is quiet outside WR and RD
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    cur_row_d     = cur_row_q;
    cur_col_d     = cur_col_q;
    cand_row_d    = cand_row_q;
    cand_col_d    = cand_col_q;
    tries_d       = tries_q;
    wait_d        = wait_q;
    char_d        = char_q;
    key_ready     = 1'b0;
    AVL_ADDR      = '0;
    AVL_BYTE_EN   = '0;
    AVL_CS        = 1'b0;
    AVL_READ      = 1'b0;
    AVL_WRITE     = 1'b0;
    AVL_WRITEDATA = '0;

    case (state_q)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          cand_row_d = cur_row_q;
          cand_col_d = cur_col_q;
          tries_d    = '0;
          if (key_code >= KEY_A && key_code <= KEY_Z) begin
            char_d  = key_code - KEY_A + CHAR_A;
            dir_d   = DIR_R;
            state_d = ST_WR;
          end else if (key_code == KEY_BKSP) begin
            char_d  = CELL_EMPTY;
            dir_d   = DIR_L;
            state_d = ST_WR;
          end else if (key_code == KEY_RIGHT) begin
            dir_d   = DIR_R;
            state_d = ST_STEP;
          end else if (key_code == KEY_LEFT) begin
            dir_d   = DIR_L;
            state_d = ST_STEP;
          end else if (key_code == KEY_DOWN) begin
            dir_d   = DIR_D;
            state_d = ST_STEP;
          end else if (key_code == KEY_UP) begin
            dir_d   = DIR_U;
            state_d = ST_STEP;
          end
        end
      end

      ST_WR: begin
        AVL_CS        = 1'b1;
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = cell_addr;
        AVL_BYTE_EN   = cell_be;
        AVL_WRITEDATA = {4{char_q}};
        state_d       = ST_STEP;
      end

      ST_STEP: begin
        // A one-cell span has nowhere to go, so skip the read entirely
        if (span == 6'd1) begin
          state_d = ST_IDLE;
        end else begin
          cand_row_d = step_row;
          cand_col_d = step_col;
          tries_d    = tries_q + 6'd1;
          state_d    = ST_RD;
        end
      end

      ST_RD: begin
        AVL_CS      = 1'b1;
        AVL_READ    = 1'b1;
        AVL_ADDR    = cell_addr;
        AVL_BYTE_EN = cell_be;
        wait_d      = '0;
        state_d     = (RD_LATENCY == 1) ? ST_CHK : ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_q == 2'(RD_LATENCY - 2)) begin
          state_d = ST_CHK;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      ST_CHK: begin
        if (rd_byte != CELL_BLOCK) begin
          cur_row_d = cand_row_q;
          cur_col_d = cand_col_q;
          state_d   = ST_IDLE;
        end else if (tries_q < span - 6'd1) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_puzzle_cursor_writer.sv
// tb/tb_puzzle_cursor_writer.sv - randomized self-checking bench for puzzle_cursor_writer
module tb_puzzle_cursor_writer;

  localparam int ROWS = 15;
  localparam int COLS = 15;
  localparam int BASE = 0;
  localparam int RDL  = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [4:0]  cursor_row, cursor_col;
  logic [12:0] AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic        AVL_CS, AVL_READ, AVL_WRITE;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA = 32'h0;

  always #5 CLK = ~CLK;

  puzzle_cursor_writer #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .BASE_WORD  (BASE),
    .RD_LATENCY (RDL)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .cursor_row    (cursor_row),
    .cursor_col    (cursor_col),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA)
  );

  typedef struct {
    bit wr;
    int addr;
    int be;
    int data;
  } txn_t;

  txn_t       exp_q[$];
  txn_t       obs_q[$];
  logic [7:0] ram [0:1023];
  int         checks = 0;
  int         errors = 0;
  int         viol = 0;
  int         m_row = 0;
  int         m_col = 0;
  int         exp_busy = 0;
  bit         pend0 = 0, pend1 = 0;
  int         paddr0 = 0, paddr1 = 0;

  // RAM slave with RD_LATENCY=2 return timing, bus monitor and quiet-bus watchdog
  always @(negedge CLK) begin
    txn_t t;
    if (pend1 && paddr1 < 256)
      AVL_READDATA = {ram[paddr1*4+3], ram[paddr1*4+2], ram[paddr1*4+1], ram[paddr1*4]};
    else
      AVL_READDATA = $urandom();
    pend1  = pend0;
    paddr1 = paddr0;
    pend0  = AVL_CS && AVL_READ;
    paddr0 = int'(AVL_ADDR);
    if (AVL_READ && AVL_WRITE) viol++;
    if (AVL_CS && (AVL_READ || AVL_WRITE)) begin
      t.wr   = AVL_WRITE;
      t.addr = int'(AVL_ADDR);
      t.be   = int'(AVL_BYTE_EN);
      t.data = int'(AVL_WRITEDATA);
      obs_q.push_back(t);
      if (AVL_WRITE && AVL_ADDR < 13'd256)
        for (int l = 0; l < 4; l++)
          if (AVL_BYTE_EN[l]) ram[int'(AVL_ADDR)*4+l] = AVL_WRITEDATA[l*8 +: 8];
    end else if (AVL_CS || AVL_READ || AVL_WRITE || AVL_BYTE_EN != 4'h0 || AVL_WRITEDATA != 32'h0) begin
      viol++;
    end
  end

  // Reference model: predicts bus traffic, busy time and new cursor from the grid rules
  task automatic predict(input logic [7:0] code);
    int dr, dc, span, r, c, idx, ch;
    bit wr, mv;
    txn_t t;
    exp_q.delete();
    exp_busy = 0;
    wr = 0; mv = 1; dr = 0; dc = 0; ch = 0;
    if (code >= 8'h04 && code <= 8'h1D) begin wr = 1; ch = 32'h41 + int'(code) - 4; dc = 1; end
    else if (code == 8'h2A) begin wr = 1; ch = 0; dc = -1; end
    else if (code == 8'h4F) dc = 1;
    else if (code == 8'h50) dc = -1;
    else if (code == 8'h51) dr = 1;
    else if (code == 8'h52) dr = -1;
    else mv = 0;
    if (!mv) return;
    if (wr) begin
      idx = m_row * COLS + m_col;
      t = '{1'b1, BASE + idx / 4, 1 << (idx % 4), ch * 32'h01010101};
      exp_q.push_back(t);
      exp_busy = 1;
    end
    span = (dc != 0) ? COLS : ROWS;
    if (span == 1) begin
      exp_busy += 1;
      return;
    end
    for (int k = 1; k < span; k++) begin
      r = ((m_row + dr * k) % ROWS + ROWS) % ROWS;
      c = ((m_col + dc * k) % COLS + COLS) % COLS;
      idx = r * COLS + c;
      t = '{1'b0, BASE + idx / 4, 1 << (idx % 4), 0};
      exp_q.push_back(t);
      exp_busy += RDL + 2;
      if (ram[BASE*4 + idx] != 8'h23) begin
        m_row = r;
        m_col = c;
        break;
      end
    end
  endtask

  task automatic do_key(input logic [7:0] code, input bit noise);
    int busy, o_row, o_col, n;
    bit early, done;
    o_row = m_row;
    o_col = m_col;
    predict(code);
    obs_q.delete();
    @(negedge CLK);
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL key_ready_idle: got %b want 1", key_ready); end
    key_code = code;
    key_valid = 1'b1;
    @(posedge CLK);
    #1;
    key_valid = 1'b0;
    key_code = 8'h00;
    busy = 0; early = 0; done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      key_valid = 1'b0;
      if (key_ready === 1'b1) begin done = 1; break; end
      busy++;
      if (int'(cursor_row) != o_row || int'(cursor_col) != o_col) early = 1;
      if (noise && busy == 2) begin key_code = 8'h51; key_valid = 1'b1; end
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (!done) begin errors++; $display("FAIL timeout key %h: key_ready never returned", code); end
    checks++;
    if (busy != exp_busy) begin errors++; $display("FAIL busy_cycles key %h: got %0d want %0d", code, busy, exp_busy); end
    checks++;
    if (early) begin errors++; $display("FAIL cursor_early key %h: got moved want held", code); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL txn_count key %h: got %0d want %0d", code, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].wr != exp_q[i].wr || obs_q[i].addr != exp_q[i].addr || obs_q[i].be != exp_q[i].be ||
          (exp_q[i].wr && obs_q[i].data != exp_q[i].data)) begin
        errors++;
        $display("FAIL txn[%0d] key %h: got wr=%0d addr=%0d be=%h data=%h want wr=%0d addr=%0d be=%h data=%h",
                 i, code, obs_q[i].wr, obs_q[i].addr, obs_q[i].be, obs_q[i].data,
                 exp_q[i].wr, exp_q[i].addr, exp_q[i].be, exp_q[i].data);
      end
    end
    checks++;
    if (int'(cursor_row) != m_row || int'(cursor_col) != m_col) begin
      errors++; $display("FAIL cursor key %h: got (%0d,%0d) want (%0d,%0d)", code, cursor_row, cursor_col, m_row, m_col);
    end
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL key_ready_after key %h: got %b want 1", code, key_ready); end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({AVL_ADDR, AVL_BYTE_EN, AVL_CS, AVL_READ, AVL_WRITE, AVL_WRITEDATA} !== 53'd0) begin
      errors++; $display("FAIL %s_avl: got addr=%h be=%h cs=%b rd=%b wr=%b wd=%h want all 0",
                         name, AVL_ADDR, AVL_BYTE_EN, AVL_CS, AVL_READ, AVL_WRITE, AVL_WRITEDATA);
    end
    checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      errors++; $display("FAIL %s_cursor: got (%0d,%0d) want (0,0)", name, cursor_row, cursor_col);
    end
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL %s_key_ready: got %b want 1", name, key_ready); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    repeat (3) @(negedge CLK);
    check_quiet("reset_held");
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check_quiet("reset_released");
    m_row = 0;
    m_col = 0;
  endtask

  task automatic test_letter();
    do_key(8'h04, 0);
    checks++;
    if (ram[0] !== 8'h41) begin errors++; $display("FAIL letter_ram: got %h want 41", ram[0]); end
    checks++;
    if (cursor_col !== 5'd1) begin errors++; $display("FAIL letter_col: got %0d want 1", cursor_col); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 13; i++) do_key(8'h4F, 0);
    do_key(8'h4F, 0);
    checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      errors++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_skip_blocks();
    ram[1] = 8'h23;
    ram[2] = 8'h23;
    do_key(8'h4F, 0);
    checks++;
    if (cursor_col !== 5'd3) begin errors++; $display("FAIL skip_col: got %0d want 3", cursor_col); end
  endtask

  task automatic test_all_blocked();
    do_key(8'h50, 0);
    for (int i = 1; i < COLS; i++) ram[i] = 8'h23;
    do_key(8'h50, 0);
    checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      errors++; $display("FAIL blocked_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_backspace_drop();
    for (int i = 1; i < COLS; i++) ram[i] = 8'h00;
    ram[35] = 8'h58;
    do_key(8'h51, 0);
    do_key(8'h51, 0);
    for (int i = 0; i < 5; i++) do_key(8'h4F, 0);
    do_key(8'h2A, 1);
    checks++;
    if (ram[35] !== 8'h00) begin errors++; $display("FAIL bksp_ram: got %h want 00", ram[35]); end
    checks++;
    if (cursor_row !== 5'd2 || cursor_col !== 5'd4) begin
      errors++; $display("FAIL bksp_cursor: got (%0d,%0d) want (2,4)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_reset_mid();
    ram[49] = 8'h00;
    @(negedge CLK);
    key_code = 8'h51;
    key_valid = 1'b1;
    @(posedge CLK);
    #1;
    key_valid = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (key_ready !== 1'b0) begin errors++; $display("FAIL mid_busy: got key_ready %b want 0", key_ready); end
    RESET = 1'b0;
    #1;
    check_quiet("mid_reset");
    obs_q.delete();
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check_quiet("mid_release");
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL mid_bus: got %0d txns want 0", obs_q.size()); end
    m_row = 0;
    m_col = 0;
    do_key(8'h4F, 0);
  endtask

  task automatic test_random();
    logic [7:0] code;
    for (int i = 0; i < ROWS * COLS; i++) ram[BASE*4 + i] = ($urandom_range(0, 3) == 0) ? 8'h23 : 8'h00;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: code = 8'(4 + $urandom_range(0, 25));
        4:       code = 8'h2A;
        5:       code = 8'h4F;
        6:       code = 8'h50;
        7:       code = 8'h51;
        8:       code = 8'h52;
        default: code = 8'($urandom_range(0, 255));
      endcase
      do_key(code, $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic test_quiet_bus();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL quiet_bus: got %0d stray strobe cycles want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_letter();
    test_wrap();
    test_skip_blocks();
    test_all_blocked();
    test_backspace_drop();
    test_reset_mid();
    test_random();
    test_quiet_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
